// File: rtl/rng_conditioner.sv
// rng_conditioner: warms up, XOR-folds DECIM raw CA samples per output word and
// buffers the words in a small FIFO with overflow drop counting.
// Optional repetition-count health test enabled by RNG_CONDITIONER_HEALTH_EN;
// without it the ALARM state is unreachable and alarm is tied low.
module rng_conditioner #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned WARMUP     = 16,
    parameter int unsigned RCT_CUTOFF = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         state,
    input  logic                     clear_alarm,
    input  logic                     rng_ready,
    output logic                     rng_valid,
    output logic [WIDTH-1:0]         rng_data,
    output logic                     alarm,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = 4;
    localparam int unsigned WW = 8;

    // Elaboration-time parameter legality checks
    if (DECIM < 1 || DECIM > 16) begin : g_bad_decim
        $error("rng_conditioner: DECIM must be 1..16");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rng_conditioner: DEPTH must be a power of two in 2..16");
    end
    if (WARMUP < 1 || WARMUP > 255) begin : g_bad_warmup
        $error("rng_conditioner: WARMUP must be 1..255");
    end
    if (RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_bad_rct
        $error("rng_conditioner: RCT_CUTOFF must be 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_ALARM  = 2'd3
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [WW-1:0]     warm_cnt;
    logic [DW-1:0]     samp_cnt;
    logic [WIDTH-1:0]  acc;
    logic              fire;
    logic              warm_done;
    logic              fold_done;
    logic              push;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              pop, full, push_ok, drop;
    logic [LW-1:0]     level_d;

`ifdef RNG_CONDITIONER_HEALTH_EN
    logic [WIDTH-1:0]  prev_sample;
    logic [7:0]        rep_q, rep_d;
    logic              health_on;

    // Repetition count over consecutive samples while warming up or running
    always_comb begin
        health_on = (fsm_q == ST_WARMUP) || (fsm_q == ST_RUN);
        rep_d     = 8'd1;
        if (health_on && rep_q != 8'd0 && state == prev_sample) begin
            rep_d = rep_q + 8'd1;
        end
        fire = health_on && (rep_d == 8'(RCT_CUTOFF));
    end

    // Previous sample, run length and alarm flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_sample <= '0;
            rep_q       <= '0;
            alarm       <= 1'b0;
        end else begin
            prev_sample <= state;
            rep_q       <= (health_on && !fire) ? rep_d : 8'd0;
            alarm       <= (fsm_d == ST_ALARM);
        end
    end
`else
    assign fire  = 1'b0;
    assign alarm = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next state and push request; a health failure overrides everything
    always_comb begin
        fsm_d     = fsm_q;
        push      = 1'b0;
        warm_done = (warm_cnt == WW'(WARMUP - 1));
        fold_done = (samp_cnt == DW'(DECIM - 1));
        if (fire) begin
            fsm_d = ST_ALARM;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (en) fsm_d = ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (!en)            fsm_d = ST_IDLE;
                    else if (warm_done) fsm_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!en)            fsm_d = ST_IDLE;
                    else if (fold_done) push  = 1'b1;
                end
                ST_ALARM: begin
                    if (clear_alarm) fsm_d = en ? ST_WARMUP : ST_IDLE;
                end
                default: fsm_d = ST_IDLE;
            endcase
        end
    end

    // Warm-up counter, fold counter and accumulator; cleared unless actively consuming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_cnt <= '0;
            samp_cnt <= '0;
            acc      <= '0;
        end else begin
            warm_cnt <= '0;
            samp_cnt <= '0;
            acc      <= '0;
            if (!fire && en) begin
                if (fsm_q == ST_WARMUP && !warm_done) begin
                    warm_cnt <= warm_cnt + WW'(1);
                end
                if (fsm_q == ST_RUN && !fold_done) begin
                    acc      <= acc ^ state;
                    samp_cnt <= samp_cnt + DW'(1);
                end
            end
        end
    end

    // FIFO control: pop frees a slot for a same-cycle push into a full FIFO
    always_comb begin
        pop     = rng_valid && rng_ready;
        full    = (level == LW'(DEPTH));
        push_ok = push && (!full || pop);
        drop    = push && !push_ok;
        level_d = level;
        if (push_ok && !pop)      level_d = level + LW'(1);
        else if (!push_ok && pop) level_d = level - LW'(1);
    end

    // FIFO storage; only completely folded words are ever written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= acc ^ state;
        end
    end

    // FIFO pointers, occupancy, valid flag and drop counter; alarm entry flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rng_valid <= 1'b0;
            drop_cnt  <= '0;
        end else if (fire) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rng_valid <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            level     <= level_d;
            rng_valid <= (level_d != '0);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign rng_data = mem[rd_ptr];

endmodule
